// File: rtl/fp_add_sequencer.sv
// Multi-cycle binary32 add/subtract sequencer: unpack/swap, align, add, then
// a one-bit-per-cycle normalizer. Truncating, flush-to-zero, one op in flight.
module fp_add_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned MANT_W = FRAC_W + 1;
   localparam int unsigned SUM_W  = MANT_W + 1;
   localparam int unsigned MAX_SHIFT = SUM_W;

   localparam logic [EXP_W-1:0] EXP_MAX = '1;
   localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALIGN = 3'd1,
      S_ADD   = 3'd2,
      S_NORM  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } op_t;

   state_t            state_q, state_d;
   op_t               op_l_q, op_l_d;
   op_t               op_s_q, op_s_d;
   logic              special_q, special_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [31:0]       result_q, result_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;

   op_t               op_a_c, op_b_c;
   logic              swap_c;
   logic [EXP_W-1:0]  diff_c;
   logic [EXP_W-1:0]  exp_inc_c;
   logic              nan_out_c;

   // Unpack with flush of zero/denormal inputs; B sign inverted for subtract.
   always_comb begin
      op_a_c.sign = a[31];
      op_a_c.exp  = (a[30:23] == '0) ? '0 : a[30:23];
      op_a_c.mant = (a[30:23] == '0) ? '0 : {1'b1, a[22:0]};
      op_b_c.sign = b[31] ^ sub;
      op_b_c.exp  = (b[30:23] == '0) ? '0 : b[30:23];
      op_b_c.mant = (b[30:23] == '0) ? '0 : {1'b1, b[22:0]};
      swap_c      = {op_b_c.exp, op_b_c.mant} > {op_a_c.exp, op_a_c.mant};
   end

   assign diff_c    = op_l_q.exp - op_s_q.exp;
   assign exp_inc_c = op_l_q.exp + EXP_W'(1);
   // L holds any NaN (largest magnitude); opposite-signed infinities also yield NaN.
   assign nan_out_c = ((op_l_q.exp == EXP_MAX) && (op_l_q.mant[FRAC_W-1:0] != '0)) ||
                      ((op_s_q.exp == EXP_MAX) && (op_l_q.sign != op_s_q.sign));

   assign in_ready  = (state_q == S_IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign busy      = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_l_q      <= '0;
         op_s_q      <= '0;
         special_q   <= 1'b0;
         sum_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_l_q      <= op_l_d;
         op_s_q      <= op_s_d;
         special_q   <= special_d;
         sum_q       <= sum_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_l_d    = op_l_q;
      op_s_d    = op_s_q;
      special_d = special_q;
      sum_d     = sum_q;
      result_d  = result_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               op_l_d    = swap_c ? op_b_c : op_a_c;
               op_s_d    = swap_c ? op_a_c : op_b_c;
               special_d = (a[30:23] == EXP_MAX) || (b[30:23] == EXP_MAX);
               state_d   = S_ALIGN;
            end
         end
         S_ALIGN: begin
            op_s_d.mant = (diff_c >= EXP_W'(MAX_SHIFT)) ? '0 : (op_s_q.mant >> diff_c);
            state_d     = S_ADD;
         end
         S_ADD: begin
            if (op_l_q.sign == op_s_q.sign)
               sum_d = {1'b0, op_l_q.mant} + {1'b0, op_s_q.mant};
            else
               sum_d = {1'b0, op_l_q.mant} - {1'b0, op_s_q.mant};
            state_d = S_NORM;
         end
         S_NORM: begin
            if (special_q) begin
               result_d = nan_out_c ? QNAN : {op_l_q.sign, EXP_MAX, FRAC_W'(0)};
               state_d  = S_DONE;
            end else if (sum_q == '0) begin
               result_d = '0;
               state_d  = S_DONE;
            end else if (sum_q[SUM_W-1]) begin
               sum_d      = sum_q >> 1;
               op_l_d.exp = exp_inc_c;
               result_d   = (exp_inc_c == EXP_MAX) ? {op_l_q.sign, EXP_MAX, FRAC_W'(0)}
                                                   : {op_l_q.sign, exp_inc_c, sum_q[FRAC_W:1]};
               state_d    = S_DONE;
            end else if (sum_q[FRAC_W]) begin
               result_d = {op_l_q.sign, op_l_q.exp, sum_q[FRAC_W-1:0]};
               state_d  = S_DONE;
            end else if (op_l_q.exp == EXP_W'(1)) begin
               // Next shift would underflow the exponent: flush to +0.
               result_d = '0;
               state_d  = S_DONE;
            end else begin
               sum_d      = sum_q << 1;
               op_l_d.exp = op_l_q.exp - EXP_W'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: directed vector table, handshake/reset corner
// sequences, and random operands against a closed-form reference model.
module tb_fp_add_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int n_tests;
   int n_fail;

   fp_add_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Reference: closed-form leading-one search instead of stepping a normalizer.
   task automatic ref_model(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                            output logic [31:0] r, output int lat);
      int          ea, eb, el, es, d, p, k;
      int unsigned ma, mb, ml, ms, sum;
      logic        sa, sb, sl, ss;
      logic        nan_a, nan_b;
      sa = ia[31];
      sb = ib[31] ^ isub;
      ea = int'(ia[30:23]);
      eb = int'(ib[30:23]);
      ma = (ea == 0) ? 0 : 32'({1'b1, ia[22:0]});
      mb = (eb == 0) ? 0 : 32'({1'b1, ib[22:0]});
      lat = 3;
      if (ea == 255 || eb == 255) begin
         nan_a = (ea == 255) && (ia[22:0] != 0);
         nan_b = (eb == 255) && (ib[22:0] != 0);
         if (nan_a || nan_b) r = 32'h7FC0_0000;
         else if (ea == 255 && eb == 255 && sa != sb) r = 32'h7FC0_0000;
         else if (ea == 255) r = {sa, 8'hFF, 23'h0};
         else r = {sb, 8'hFF, 23'h0};
         return;
      end
      if (eb > ea || (eb == ea && mb > ma)) begin
         el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa;
      end else begin
         el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb;
      end
      d  = el - es;
      ms = (d >= 25) ? 0 : (ms >> d);
      sum = (sl == ss) ? ml + ms : ml - ms;
      if (sum == 0) begin
         r = 32'h0;
         return;
      end
      p = -1;
      for (int i = 0; i < 25; i++) if (sum[i]) p = i;
      if (p == 24) begin
         if (el + 1 == 255) r = {sl, 8'hFF, 23'h0};
         else r = {sl, 8'(el + 1), 23'((sum >> 1) & 32'h7F_FFFF)};
      end else begin
         k = 23 - p;
         if (k >= el) begin
            r   = 32'h0;
            lat = 2 + el;
         end else begin
            r   = {sl, 8'(el - k), 23'((sum << k) & 32'h7F_FFFF)};
            lat = 3 + k;
         end
      end
   endtask

   // Issue one operation and wait for out_valid; leaves the DUT in DONE.
   task automatic start_wait(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                             output logic [31:0] r, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      a = ia; b = ib; sub = isub; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      if (lat >= 40) begin
         n_tests++; n_fail++;
         $display("FAIL timeout: no out_valid within 40 cycles (a=%08h b=%08h)", ia, ib);
      end
      r = result;
   endtask

   task automatic release_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   vec_t        vecs[14];
   logic [31:0] r, exp_r;
   int          lat, exp_lat;
   logic [31:0] ra, rb;
   logic        rs;
   int          mode, e, e2;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0; n_fail = 0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0;

      vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3};
      vecs[1]  = '{32'h3FC0_0000, 32'h3FA0_0000, 1'b1, 32'h3E80_0000, 5};
      vecs[2]  = '{32'h4049_0FDB, 32'h4049_0FDB, 1'b1, 32'h0000_0000, 3};
      vecs[3]  = '{32'h4C00_0000, 32'h3F80_0000, 1'b0, 32'h4C00_0000, 3};
      vecs[4]  = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 3};
      vecs[5]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3};
      vecs[6]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 3};
      vecs[7]  = '{32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000, 3};
      vecs[8]  = '{32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000, 3};
      vecs[9]  = '{32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 4};
      vecs[10] = '{32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000, 3};
      vecs[11] = '{32'hFF80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000, 3};
      vecs[12] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 3};
      vecs[13] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 3};

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'h0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Directed table.
      foreach (vecs[i]) begin
         start_wait(vecs[i].a, vecs[i].b, vecs[i].sub, r, lat);
         chk($sformatf("vec%0d_result", i), r, vecs[i].res);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         release_op();
         chk($sformatf("vec%0d_idle_in_ready", i), 32'(in_ready), 32'd1);
         chk($sformatf("vec%0d_idle_out_valid", i), 32'(out_valid), 32'd0);
      end

      // Backpressure in DONE with ignored in_valid pulses.
      start_wait(32'h3F80_0000, 32'h3F80_0000, 1'b0, r, lat);
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'(c % 2);
         a = 32'h4000_0000; b = 32'h4000_0000;
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_result", result, 32'h4000_0000);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
      end
      in_valid = 1'b0;
      release_op();
      chk("bp_rel_out_valid", 32'(out_valid), 32'd0);
      chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
      chk("bp_rel_busy", 32'(busy), 32'd0);

      // Reset during NORM of 1.5-1.25.
      a = 32'h3FC0_0000; b = 32'h3FA0_0000; sub = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midop_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("midop_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("midop_out_valid", 32'(out_valid), 32'd0);
      chk("midop_result", result, 32'h0);
      chk("midop_busy_after", 32'(busy), 32'd0);
      rst = 1'b0;
      #1;
      chk("midop_in_ready_after", 32'(in_ready), 32'd1);
      start_wait(32'h3F80_0000, 32'h3F80_0000, 1'b0, r, lat);
      chk("after_rst_result", r, 32'h4000_0000);
      chk("after_rst_latency", 32'(lat), 32'd3);
      release_op();

      // Reset coinciding with a handshake discards it.
      rst = 1'b1; in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000; sub = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_hs_busy", 32'(busy), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("rst_hs_out_valid", 32'(out_valid), 32'd0);

      // Random operands against the reference model.
      for (int t = 0; t < 200; t++) begin
         mode = int'($urandom_range(0, 9));
         if (mode == 0) begin
            ra = $urandom; rb = $urandom;
         end else if (mode == 1) begin
            ra = {1'($urandom), 8'hFF, ($urandom_range(0, 1) == 0) ? 23'h0 : 23'($urandom)};
            rb = ($urandom_range(0, 1) == 0) ? {1'($urandom), 8'hFF, 23'h0} : $urandom;
         end else begin
            e  = (mode == 2) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 253));
            e2 = e - int'($urandom_range(0, 2));
            if (e2 < 0) e2 = 0;
            ra = {1'($urandom), 8'(e), 23'($urandom)};
            rb = {1'($urandom), 8'(e2),
                  ($urandom_range(0, 1) == 0) ? (ra[22:0] ^ 23'($urandom & 32'hFF)) : 23'($urandom)};
            if ($urandom_range(0, 1) == 0) begin
               ra = ra ^ rb; rb = ra ^ rb; ra = ra ^ rb;
            end
         end
         rs = 1'($urandom);
         ref_model(ra, rb, rs, exp_r, exp_lat);
         start_wait(ra, rb, rs, r, lat);
         chk($sformatf("rand%0d_result a=%08h b=%08h sub=%0d", t, ra, rb, rs), r, exp_r);
         chk($sformatf("rand%0d_latency", t), 32'(lat), 32'(exp_lat));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         release_op();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_add_sequencer.md
# fp_add_sequencer

Multi-cycle controller for the single-precision floating-point add/subtract datapath. It accepts one operand pair through a valid/ready handshake and sequences the add through four stages: operand swap/unpack, exponent alignment, mantissa add/subtract, and iterative normalization. Normalization shifts one bit per cycle under a counter, replacing a wide priority-encoder normalizer, so latency depends on the data. The block sits between the issue logic and the result writeback, and holds one operation in flight.

## Interface
- Parameters: none. Format is fixed IEEE-754 binary32: 8-bit exponent, 23-bit fraction, hidden bit, 25-bit internal sum.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept; high only in IDLE and while rst is low.
- a  in  32  operand A, binary32.
- b  in  32  operand B, binary32.
- sub  in  1  1 = compute a-b (B sign inverted at accept), 0 = a+b.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer takes result.
- result  out  32  binary32 result, registered.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ALIGN, ADD, NORM, DONE. Reset (sync, rst=1 at an edge) forces IDLE from any state, including mid-operation.
- Reset values: out_valid=0, result=32'h0, busy=0, all internal registers 0. in_ready=0 while rst=1, and 1 on the first cycle after.
- IDLE: when in_valid&&in_ready at an edge, register the unpacked operands and go to ALIGN.
  - Unpacked fields: sign, exp, 24-bit mantissa with the hidden bit.
  - Exp==0 operands (zero/denormal) are flushed: mantissa=0, exp=0.
  - Swap so the larger-magnitude operand is L. Compare {exp,mant}; on a tie, keep A as L.
  - Special flag is registered when either exp==255.
- ALIGN: diff = expL-expS.
  - mS >>= diff; if diff>=25, mS=0. Shifted-out bits are discarded (truncation; no guard/round/sticky bits).
  - Then go to ADD.
- ADD: 25-bit sum.
  - Signs equal: sum = mL+mS.
  - Signs differ: sum = mL-mS, which is never negative because of the swap.
  - Result sign = sign of L. Then go to NORM.
- NORM, evaluated once per cycle:
  - Special flag set: result computed by the special-case rules below; go to DONE.
  - sum==0: result=32'h00000000 (+0, including exact cancellation); go to DONE.
  - sum[24]=1: sum>>=1, exp+1. If the new exp is 255, result = signed infinity. Go to DONE.
  - sum[23]=1: pack {sign, exp, sum[22:0]}; go to DONE.
  - Otherwise: sum<<=1, exp-1, stay in NORM. If exp would reach 0, flush: result=+0, go to DONE.
- Special cases:
  - Any NaN → 32'h7FC00000.
  - +inf + -inf (after sub applied) → 32'h7FC00000.
  - inf with a finite operand → that infinity.
  - inf with same-sign inf → that infinity.
- DONE: result is held stable.
  - out_valid&&out_ready at an edge → IDLE.
  - in_ready rises the next cycle; there is no same-cycle turnaround.
- in_valid is ignored outside IDLE. a, b and sub are sampled only at the accept edge.

## Timing
- Accept edge E0 → ALIGN; E1 → ADD; E2 → NORM; NORM exit edge → DONE.
- out_valid is first high after edge E3+k. k is the number of left-shift cycles (0..23).
- k=0 for carry-out, already-normalized, zero and special results. Minimum latency is 3 cycles.
- Worst case: 26 cycles from accept to out_valid.
- Throughput: one operation per (latency + 1 + consumer wait) cycles.
- result and out_valid change only at edges; there is no combinational path from a/b to the outputs.
- rst asserted at the same edge as a handshake: reset wins, and the handshake is discarded.

## Test plan
- 1.0+1.0: a=32'h3F800000, b=32'h3F800000, sub=0 → result=32'h40000000 (carry path); out_valid 3 cycles after accept.
- 1.5-1.25: a=32'h3FC00000, b=32'h3FA00000, sub=1 → result=32'h3E800000, k=2; out_valid 5 cycles after accept.
- Cancellation: a=b=32'h40490FDB, sub=1 → result=32'h00000000, latency 3. Large diff: a=32'h4C000000, b=32'h3F800000 → result=32'h4C000000.
- Specials/overflow:
  - 32'h7F800000 + 32'hFF800000 → 32'h7FC00000.
  - 32'h7F7FFFFF + 32'h7F7FFFFF → 32'h7F800000.
  - 32'h7FC00001 + 32'h3F800000 → 32'h7FC00000.
- Backpressure: hold out_ready=0 for 6 cycles in DONE → result and out_valid stay stable, in_ready=0, and in_valid pulses are ignored. Release out_ready → IDLE, then in_ready=1 one cycle later.
- Reset mid-op: start 1.5-1.25, assert rst during NORM → next edge: IDLE, out_valid=0, result=0, busy=0. A new 1.0+1.0 then completes correctly.
